// File: rtl/tdm_demux_1_4.sv
// 1-to-4 demultiplexer: steers a handshaked input stream into four one-entry
// lane registers, either round-robin with frame alignment or by explicit select.

module tdm_demux_1_4_lane #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_wr,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid
);
    logic [W-1:0] r_data;
    logic         r_valid;

    // A write wins over a drain, so refill-while-draining keeps the lane full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_wr) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
endmodule

module tdm_demux_1_4 #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_sof,
    output logic         in_ready,
    input  logic         sel_mode,
    input  logic [1:0]   sel,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b,
    output logic [W-1:0] out_c,
    output logic [W-1:0] out_d,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [1:0]   slot,
    output logic         frame_done,
    output logic         sync_err
);
    logic [1:0]          w_tgt;
    logic                w_accept;
    logic                w_rr_accept;
    logic [3:0]          w_wr;
    logic [3:0][W-1:0]   w_lane_data;
    logic [3:0]          w_lane_valid;

    logic [1:0]          r_slot;
    logic                r_frame_done;
    logic                r_sync_err;

    // Target lane depends only on control inputs and state, never on in_valid.
    always_comb begin
        w_tgt = r_slot;
        if (sel_mode)
            w_tgt = sel;
        else if (in_sof)
            w_tgt = 2'd0;
    end

    assign in_ready    = !w_lane_valid[w_tgt] || out_ready[w_tgt];
    assign w_accept    = in_valid && in_ready;
    assign w_rr_accept = w_accept && !sel_mode;

    always_comb begin
        w_wr        = '0;
        w_wr[w_tgt] = w_accept;
    end

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_lane
            tdm_demux_1_4_lane #(.W(W)) u_lane (
                .clk     (clk),
                .rst     (rst),
                .i_wr    (w_wr[g]),
                .i_data  (in_data),
                .i_ready (out_ready[g]),
                .o_data  (w_lane_data[g]),
                .o_valid (w_lane_valid[g])
            );
        end
    endgenerate

    // Slot only advances on RR accepts; an in_sof accept realigns it to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot       <= 2'd0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            if (w_rr_accept)
                r_slot <= w_tgt + 2'd1;
            r_frame_done <= w_rr_accept && (w_tgt == 2'd3);
            r_sync_err   <= w_rr_accept && in_sof && (r_slot != 2'd0);
        end
    end

    assign out_a      = w_lane_data[0];
    assign out_b      = w_lane_data[1];
    assign out_c      = w_lane_data[2];
    assign out_d      = w_lane_data[3];
    assign out_valid  = w_lane_valid;
    assign slot       = r_slot;
    assign frame_done = r_frame_done;
    assign sync_err   = r_sync_err;
endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Directed bench for tdm_demux_1_4: RR distribution, backpressure/refill,
// sof realignment, explicit select and asynchronous reset.

module tb_tdm_demux_1_4;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic       sel_mode = 1'b0;
    logic [1:0] sel = '0;
    logic [3:0] out_ready = 4'b1111;
    logic       in_ready;
    logic [1:0] out_a, out_b, out_c, out_d;
    logic [3:0] out_valid;
    logic [1:0] slot;
    logic       frame_done, sync_err;

    int checks = 0;
    int errors = 0;

    tdm_demux_1_4 #(.W(2)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_sof(in_sof), .in_ready(in_ready), .sel_mode(sel_mode), .sel(sel),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
        .out_valid(out_valid), .out_ready(out_ready), .slot(slot),
        .frame_done(frame_done), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({out_valid, slot, frame_done, sync_err, in_ready} !== {4'b0000, 2'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_ctl: got valid=%b slot=%0d fd=%b se=%b rdy=%b, want 0000 0 0 0 1",
                     out_valid, slot, frame_done, sync_err, in_ready);
        end
        checks++;
        if ({out_a, out_b, out_c, out_d} !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h want 00", {out_a, out_b, out_c, out_d});
        end
        tick();
        #2 rst = 1'b0;
    endtask

    task automatic test_rr();
        logic [7:0] lanes;
        sel_mode  = 1'b0;
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            in_data  = 2'(i);
            in_sof   = (i == 0);
            in_valid = 1'b1;
            #1;
            checks++;
            if ({in_ready, slot} !== {1'b1, 2'(i)}) begin
                errors++;
                $display("FAIL rr_pre%0d: got rdy=%b slot=%0d want 1 %0d", i, in_ready, slot, i);
            end
            tick();
            lanes = {out_d, out_c, out_b, out_a};
            checks++;
            if ({lanes[2*i +: 2], out_valid, slot, frame_done, sync_err} !==
                {2'(i), 4'(1 << i), 2'(i + 1), (i == 3), 1'b0}) begin
                errors++;
                $display("FAIL rr_post%0d: got data=%0d valid=%b slot=%0d fd=%b se=%b want %0d %b %0d %b 0",
                         i, lanes[2*i +: 2], out_valid, slot, frame_done, sync_err,
                         i, 4'(1 << i), (i + 1) % 4, (i == 3));
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        tick();
        checks++;
        if ({out_valid, frame_done} !== {4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL rr_idle: got valid=%b fd=%b want 0000 0", out_valid, frame_done);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] data_q [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [3:0] vld_q  [5] = '{4'b0001, 4'b0010, 4'b0110, 4'b1010, 4'b0011};
        out_ready = 4'b1101;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = data_q[i];
            tick();
            checks++;
            if ({out_valid, slot} !== {vld_q[i], 2'((i + 1) % 4)}) begin
                errors++;
                $display("FAIL bp_w%0d: got valid=%b slot=%0d want %b %0d",
                         i, out_valid, slot, vld_q[i], (i + 1) % 4);
            end
        end
        in_data = 2'd3;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall_rdy: got %b want 0", in_ready);
        end
        tick();
        checks++;
        if ({out_b, out_valid, slot} !== {2'd2, 4'b0010, 2'd1}) begin
            errors++;
            $display("FAIL bp_stall_hold: got b=%0d valid=%b slot=%0d want 2 0010 1", out_b, out_valid, slot);
        end
        out_ready = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_refill_rdy: got %b want 1", in_ready);
        end
        tick();
        checks++;
        if ({out_b, out_valid, slot} !== {2'd3, 4'b0010, 2'd2}) begin
            errors++;
            $display("FAIL bp_refill: got b=%0d valid=%b slot=%0d want 3 0010 2", out_b, out_valid, slot);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_misalign();
        // slot=2 on entry: c, d (frame_done), aligned sof to a, then b
        in_valid = 1'b1;
        in_data  = 2'd1;
        tick();
        in_data  = 2'd2;
        tick();
        checks++;
        if ({out_d, slot, frame_done} !== {2'd2, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL mis_wrap: got d=%0d slot=%0d fd=%b want 2 0 1", out_d, slot, frame_done);
        end
        in_sof  = 1'b1;
        in_data = 2'd0;
        tick();
        checks++;
        if ({slot, sync_err} !== {2'd1, 1'b0}) begin
            errors++;
            $display("FAIL mis_aligned_sof: got slot=%0d se=%b want 1 0", slot, sync_err);
        end
        in_sof  = 1'b0;
        in_data = 2'd1;
        tick();
        in_sof  = 1'b1;
        in_data = 2'd3;
        #1;
        checks++;
        if ({slot, in_ready} !== {2'd2, 1'b1}) begin
            errors++;
            $display("FAIL mis_pre: got slot=%0d rdy=%b want 2 1", slot, in_ready);
        end
        tick();
        checks++;
        if ({out_a, out_valid[0], slot, sync_err} !== {2'd3, 1'b1, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL mis_post: got a=%0d va=%b slot=%0d se=%b want 3 1 1 1",
                     out_a, out_valid[0], slot, sync_err);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        tick();
        checks++;
        if ({sync_err, out_valid} !== {1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL mis_pulse: got se=%b valid=%b want 0 0000", sync_err, out_valid);
        end
    endtask

    task automatic test_explicit();
        sel_mode  = 1'b1;
        sel       = 2'd2;
        in_sof    = 1'b1;
        in_data   = 2'b10;
        in_valid  = 1'b1;
        out_ready = 4'b1011;
        tick();
        checks++;
        if ({out_c, out_valid, slot, sync_err} !== {2'b10, 4'b0100, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL exp_c: got c=%b valid=%b slot=%0d se=%b want 10 0100 1 0",
                     out_c, out_valid, slot, sync_err);
        end
        in_data = 2'b01;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL exp_stall_rdy: got %b want 0", in_ready);
        end
        tick();
        checks++;
        if ({out_c, out_valid} !== {2'b10, 4'b0100}) begin
            errors++;
            $display("FAIL exp_stall_hold: got c=%b valid=%b want 10 0100", out_c, out_valid);
        end
        sel = 2'd3;
        tick();
        checks++;
        if ({out_d, out_valid, slot} !== {2'b01, 4'b1100, 2'd1}) begin
            errors++;
            $display("FAIL exp_d: got d=%b valid=%b slot=%0d want 01 1100 1", out_d, out_valid, slot);
        end
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 4'b1111;
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 4'b0000;
        sel_mode  = 1'b1;
        sel       = 2'd0;
        in_valid  = 1'b1;
        in_data   = 2'd1;
        tick();
        sel_mode  = 1'b0;
        in_data   = 2'd2;
        tick();
        in_data   = 2'd3;
        tick();
        in_valid  = 1'b0;
        checks++;
        if ({out_valid, slot} !== {4'b0111, 2'd3}) begin
            errors++;
            $display("FAIL ar_setup: got valid=%b slot=%0d want 0111 3", out_valid, slot);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, slot, frame_done, sync_err, in_ready, out_a, out_b, out_c, out_d} !==
            {4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL ar_async: got valid=%b slot=%0d fd=%b se=%b rdy=%b data=%h want 0000 0 0 0 1 00",
                     out_valid, slot, frame_done, sync_err, in_ready, {out_a, out_b, out_c, out_d});
        end
        #1 rst = 1'b0;
        out_ready = 4'b1111;
        in_data   = 2'd2;
        in_valid  = 1'b1;
        tick();
        checks++;
        if ({out_a, out_valid, slot} !== {2'd2, 4'b0001, 2'd1}) begin
            errors++;
            $display("FAIL ar_resume: got a=%0d valid=%b slot=%0d want 2 0001 1", out_a, out_valid, slot);
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_rr();
        test_backpressure();
        test_misalign();
        test_explicit();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tdm_demux_1_4.md
# tdm_demux_1_4

Sequential 1-to-4 demultiplexer: the distribution counterpart of the team's 4:1 mux tree. It accepts a W-bit input stream under a valid/ready handshake and steers each accepted word into one of four output lanes (a, b, c, d), each backed by a one-entry holding register. Lane choice is either round-robin time-division, with frame alignment via a start-of-frame marker, or an explicit 2-bit select. It sits between a shared serial source and four per-channel consumers.

## Interface
Parameters:
- W, default 2, data width of input and of each lane.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  W  input word.
- in_valid  input  1  in_data is valid.
- in_sof  input  1  qualifies in_data as the first word of a frame (slot 0); only meaningful in RR mode.
- in_ready  output  1  block can accept in_data this cycle.
- sel_mode  input  1  0 = round-robin (RR), 1 = explicit select.
- sel  input  2  target lane in explicit mode (0=a, 1=b, 2=c, 3=d).
- out_a, out_b, out_c, out_d  output  W each  lane data registers.
- out_valid  output  4  per-lane full flag; bit 0 = a … bit 3 = d.
- out_ready  input  4  per-lane consumer ready.
- slot  output  2  next RR slot.
- frame_done  output  1  one-cycle pulse after slot 3 is accepted in RR mode.
- sync_err  output  1  one-cycle pulse when in_sof is accepted while slot != 0.

## Operation
- Target lane t is decided combinationally:
  - sel_mode=1: t = sel.
  - sel_mode=0 and in_sof=1: t = 0.
  - Otherwise: t = slot.
- in_ready = !out_valid[t] | out_ready[t]. A full lane whose consumer is draining this cycle can be refilled in the same cycle.
- Accept = in_valid & in_ready. On accept, lane t's register loads in_data and out_valid[t] is set.
- Per lane, with no write this cycle: out_valid & out_ready clears out_valid. Lane data holds its last value after draining (not cleared).
- Write and drain on the same lane in the same cycle: valid stays 1, data takes the new word.
- Writes and drains on different lanes are independent and concurrent.
- Slot counter (RR mode only):
  - On accept, slot ← t+1 mod 4, so 3 wraps to 0.
  - No accept: slot holds.
  - Explicit mode: slot holds and is never modified.
- frame_done: registered; high for one cycle after an RR-mode accept with t=3.
- sync_err: registered; high for one cycle after an RR accept with in_sof=1 while slot != 0. The slot is still forced to 0, so the word goes to lane a and slot becomes 1.
- in_sof is ignored in explicit mode: no realignment, no sync_err.
- Changing sel_mode mid-stream is legal. RR resumes from the held slot value.
- No internal data path from lane to lane. The block never drops or duplicates an accepted word.

## Timing
- Reset (async assert, synchronous release at clk edge): out_valid=4'b0000, out_a..out_d=0, slot=0, frame_done=0, sync_err=0. in_ready is therefore 1 out of reset.
- Reset mid-operation: buffered words are discarded, slot returns to 0, and any pending pulse is cancelled.
- Latency: a word accepted at edge n appears on out_x with out_valid[x]=1 after edge n. One-cycle latency, one word per cycle maximum throughput.
- in_ready is a combinational function of sel_mode, sel, in_sof, slot, out_valid and out_ready. There is no combinational path from in_valid to in_ready.
- All outputs other than in_ready are registered.
- Backpressure: if lane t is full and out_ready[t]=0, the input stalls. In RR mode this stalls all lanes, which is intentional for ordering. Upstream must hold in_data, in_valid and in_sof stable until accepted.

## Test plan
- Reset then RR: sel_mode=0, out_ready=4'b1111, words 0,1,2,3 with in_sof on the first. Lanes a..d receive 0,1,2,3, each one cycle after its accept; slot sequence 0→1→2→3→0; frame_done pulses once, after word 3; sync_err stays 0.
- Backpressure: RR mode, out_ready[1]=0, send four words. Lane b fills; the next word targeting b sees in_ready=0. Raise out_ready[1] and the stalled word is accepted in that same cycle via refill, with out_valid[1] staying 1.
- Misalignment: RR mode, accept two words (slot=2), then send in_sof=1 with data 2'b11. The word lands in lane a, slot=1, and sync_err pulses exactly one cycle.
- Explicit mode: sel_mode=1, sel=2, in_data=2'b10. out_c=2'b10, out_valid=4'b0100, slot unchanged. A second write to sel=2 with out_ready[2]=0 is stalled (in_ready=0).
- Async reset mid-frame: with out_valid=4'b0111 and slot=3, assert rst between clock edges. All outputs reach reset values immediately, without waiting for a clock edge; after release the first RR word goes to lane a.
